// File: rtl/scaler_chain.sv
// scaler_chain
//   Scaler stages FS02..FS(STAGES+1) as a binary counter that advances once
//   per falling edge of the timer's FS01_n. FS01_n is resynchronised
//   internally; all state changes on the rising edge of SIM_CLK.
//
// Parameters
//   STAGES      number of scaler stages after FS01 (FS[0] = FS02)
//   SYNC_STAGES depth of the FS01_n synchroniser (>= 1)
//
// Ports
//   SIM_CLK  in   clock
//   SIM_RST  in   asynchronous reset, active-low
//   FS01_n   in   first scaler stage, idle high; each fall is one advance
//   SCLR     in   synchronous clear, active-high (beats HOLD and advance)
//   HOLD     in   synchronous freeze, active-high; advances are dropped
//   FS       out  stage levels
//   FS_n     out  complement of FS
//   STG_STB  out  one-cycle pulse per bit on a 0->1 transition of FS
//   WRAP     out  one-cycle pulse when the count rolls from all-ones to zero
module scaler_chain #(
    parameter int STAGES      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              SIM_CLK,
    input  logic              SIM_RST,
    input  logic              FS01_n,
    input  logic              SCLR,
    input  logic              HOLD,
    output logic [STAGES-1:0] FS,
    output logic [STAGES-1:0] FS_n,
    output logic [STAGES-1:0] STG_STB,
    output logic              WRAP
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic [STAGES-1:0]      count;
    logic [STAGES-1:0]      count_inc;
    logic [STAGES-1:0]      stg_stb;
    logic                   wrap;
    logic                   adv;

    assign adv       = prev & ~sync[SYNC_STAGES-1];
    assign count_inc = count + 1'b1;

    // Synchroniser and edge-detect flops reset to the idle level of FS01_n,
    // so a low input already present at reset release is counted once.
    // They keep running through SCLR/HOLD so an edge seen then is consumed.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            sync <= '1;
            prev <= 1'b1;
        end else begin
            sync[0] <= FS01_n;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync[i] <= sync[i-1];
            prev <= sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            count   <= '0;
            stg_stb <= '0;
            wrap    <= 1'b0;
        end else if (SCLR) begin
            count   <= '0;
            stg_stb <= '0;
            wrap    <= 1'b0;
        end else if (HOLD) begin
            stg_stb <= '0;
            wrap    <= 1'b0;
        end else if (adv) begin
            count   <= count_inc;
            // Only the lowest zero bit of the old count rises; none on wrap.
            stg_stb <= ~count & count_inc;
            wrap    <= &count;
        end else begin
            stg_stb <= '0;
            wrap    <= 1'b0;
        end
    end

    assign FS      = count;
    assign FS_n    = ~count;
    assign STG_STB = stg_stb;
    assign WRAP    = wrap;

endmodule

// File: tb/tb_scaler_chain.sv
module tb_scaler_chain;

    logic       SIM_CLK = 1'b0;
    logic       SIM_RST = 1'b0;
    logic       FS01_n  = 1'b1;
    logic       SCLR    = 1'b0;
    logic       HOLD    = 1'b0;
    logic [3:0] FS, FS_n, STG_STB;
    logic       WRAP;

    int ncmp = 0;
    int nerr = 0;

    scaler_chain #(.STAGES(4), .SYNC_STAGES(2)) dut (
        .SIM_CLK (SIM_CLK),
        .SIM_RST (SIM_RST),
        .FS01_n  (FS01_n),
        .SCLR    (SCLR),
        .HOLD    (HOLD),
        .FS      (FS),
        .FS_n    (FS_n),
        .STG_STB (STG_STB),
        .WRAP    (WRAP)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    task automatic tick();
        @(posedge SIM_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [3:0] fs,
                             input logic [3:0] stb, input logic wr);
        chk({tag, ".fs"},   {4'h0, FS},      {4'h0, fs});
        chk({tag, ".fs_n"}, {4'h0, FS_n},    {4'h0, ~fs});
        chk({tag, ".stb"},  {4'h0, STG_STB}, {4'h0, stb});
        chk({tag, ".wrap"}, {7'h0, WRAP},    {7'h0, wr});
    endtask

    // One 3-cycle low pulse on FS01_n, 10 cycles apart from the next.
    // Edge E0 samples the low; count must still be old after E1 and new after E2.
    task automatic pulse(input string tag, input logic [3:0] old_fs,
                         input logic [3:0] new_fs, input logic [3:0] stb,
                         input logic wr);
        FS01_n = 1'b0;
        tick();                                   // E0
        tick();                                   // E1
        chk({tag, ".lat"}, {4'h0, FS}, {4'h0, old_fs});
        tick();                                   // E2
        chk_state({tag, ".upd"}, new_fs, stb, wr);
        FS01_n = 1'b1;
        tick();
        chk_state({tag, ".one"}, new_fs, 4'h0, 1'b0);
        repeat (6) tick();
    endtask

    initial begin
        logic [3:0] c, stb;

        // Reset and idle
        tick();
        tick();
        chk_state("rst", 4'h0, 4'h0, 1'b0);
        SIM_RST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_state("idle", 4'h0, 4'h0, 1'b0);
        end

        // Basic count: 1..5 with strobes 0001,0010,0001,0100,0001
        pulse("b1", 4'h0, 4'h1, 4'b0001, 1'b0);
        pulse("b2", 4'h1, 4'h2, 4'b0010, 1'b0);
        pulse("b3", 4'h2, 4'h3, 4'b0001, 1'b0);
        pulse("b4", 4'h3, 4'h4, 4'b0100, 1'b0);
        pulse("b5", 4'h4, 4'h5, 4'b0001, 1'b0);

        // Clear, then 16 pulses through the wrap
        SCLR = 1'b1;
        tick();
        chk_state("sclr", 4'h0, 4'h0, 1'b0);
        SCLR = 1'b0;
        tick();
        for (int n = 0; n < 16; n++) begin
            c   = 4'(n);
            stb = 4'h0;
            for (int b = 3; b >= 0; b--)
                if (!c[b]) stb = 4'h0 | (4'h1 << b);
            pulse("wrap", c, 4'(n + 1), stb, n == 15);
        end

        // Long low: exactly one advance
        FS01_n = 1'b0;
        repeat (3) tick();
        chk_state("long.first", 4'h1, 4'b0001, 1'b0);
        repeat (47) tick();
        chk_state("long.end", 4'h1, 4'h0, 1'b0);
        FS01_n = 1'b1;
        repeat (5) tick();
        chk_state("long.rel", 4'h1, 4'h0, 1'b0);

        // HOLD drops advances
        HOLD = 1'b1;
        pulse("hold1", 4'h1, 4'h1, 4'h0, 1'b0);
        pulse("hold2", 4'h1, 4'h1, 4'h0, 1'b0);
        pulse("hold3", 4'h1, 4'h1, 4'h0, 1'b0);
        HOLD = 1'b0;
        tick();
        chk_state("hold.rel", 4'h1, 4'h0, 1'b0);

        // Up to 0101, then SCLR in the cycle adv is active
        pulse("p2", 4'h1, 4'h2, 4'b0010, 1'b0);
        pulse("p3", 4'h2, 4'h3, 4'b0001, 1'b0);
        pulse("p4", 4'h3, 4'h4, 4'b0100, 1'b0);
        pulse("p5", 4'h4, 4'h5, 4'b0001, 1'b0);
        FS01_n = 1'b0;
        tick();
        tick();
        SCLR = 1'b1;
        tick();
        chk_state("sclr_adv", 4'h0, 4'h0, 1'b0);
        SCLR   = 1'b0;
        FS01_n = 1'b1;
        repeat (3) tick();
        chk_state("sclr_adv.lost", 4'h0, 4'h0, 1'b0);

        // SCLR and HOLD together: clear wins
        pulse("q1", 4'h0, 4'h1, 4'b0001, 1'b0);
        SCLR = 1'b1;
        HOLD = 1'b1;
        tick();
        chk_state("sclr_hold", 4'h0, 4'h0, 1'b0);
        SCLR = 1'b0;
        HOLD = 1'b0;
        tick();

        // Async reset mid-flight at FS=0011
        pulse("r1", 4'h0, 4'h1, 4'b0001, 1'b0);
        pulse("r2", 4'h1, 4'h2, 4'b0010, 1'b0);
        pulse("r3", 4'h2, 4'h3, 4'b0001, 1'b0);
        FS01_n = 1'b0;
        tick();
        tick();
        #2 SIM_RST = 1'b0;
        #1;
        chk_state("arst.now", 4'h0, 4'h0, 1'b0);
        FS01_n = 1'b1;
        tick();
        SIM_RST = 1'b1;
        repeat (6) tick();
        chk_state("arst.after", 4'h0, 4'h0, 1'b0);

        // Low FS01_n present at reset release is counted once
        SIM_RST = 1'b0;
        FS01_n  = 1'b0;
        tick();
        SIM_RST = 1'b1;
        repeat (4) tick();
        chk_state("rel_low", 4'h1, 4'h0, 1'b0);
        repeat (10) tick();
        chk_state("rel_low.hold", 4'h1, 4'h0, 1'b0);
        FS01_n = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/scaler_chain.md
Name: scaler_chain

Overview:
- Downstream consumer of the timer's FS01_n output; forms the scaler stages FS02..FS(STAGES+1) as a binary ripple-equivalent counter advanced once per FS01 cycle.
- Produces level outputs (true and complement) plus one-cycle stage-rise strobes and a wrap strobe. The strobes feed the timing pulses used by counter-increment and standby logic.
- Fully synchronous to SIM_CLK. FS01_n is resynchronised internally.

Parameters:
- STAGES, 32, number of scaler stages after FS01; bit 0 = FS02, bit STAGES-1 = FS(STAGES+1).
- SYNC_STAGES, 2, depth of the FS01_n input synchroniser, minimum 1.

Ports:
- SIM_CLK  in  1  simulation clock; all state changes on its rising edge.
- SIM_RST  in  1  asynchronous reset, active-low.
- FS01_n  in  1  first scaler stage from the timer, idle high; each high-to-low transition is one advance request.
- SCLR  in  1  synchronous clear (monitor/test), active-high.
- HOLD  in  1  synchronous freeze, active-high; advances arriving while HOLD=1 are dropped.
- FS  out  STAGES  scaler stage levels; FS[k] = stage k+2.
- FS_n  out  STAGES  bitwise complement of FS, always consistent in the same cycle.
- STG_STB  out  STAGES  one-cycle pulse per bit on a 0->1 transition of the corresponding FS bit.
- WRAP  out  1  one-cycle pulse when the count rolls from all-ones to zero.

Behaviour:
- Reset (SIM_RST=0, asynchronous):
  - count=0, so FS=0 and FS_n=all-ones.
  - STG_STB=0, WRAP=0.
  - All synchroniser flops and the previous-sample flop are set to 1 (the idle value of FS01_n).
- Synchroniser: shift chain s[0..SYNC_STAGES-1] sampling FS01_n; prev captures s[SYNC_STAGES-1] every edge.
- Advance detect: adv = prev & ~s[SYNC_STAGES-1] (a falling edge of the synchronised FS01_n). FS01_n held low produces exactly one adv.
- Latency: when edge E0 first samples FS01_n low, count changes at edge E0+SYNC_STAGES. STG_STB and WRAP are registered at that same edge, so they are high in the same cycle the new count is visible, for exactly one cycle.
- Priority per edge: SCLR > HOLD > adv.
  - SCLR=1: count<=0; STG_STB<=0, WRAP<=0. The synchroniser and prev keep running, so an edge pending during SCLR is consumed and lost.
  - HOLD=1 (SCLR=0): count unchanged; strobes<=0; a pending adv is discarded, not queued.
  - adv=1: count<=count+1 mod 2^STAGES. STG_STB<=(~count)&(count+1), giving exactly one bit set per advance: the lowest zero bit of the old count, or none on wrap. WRAP<=1 iff old count was all-ones.
  - Otherwise: count holds; STG_STB<=0, WRAP<=0.
- Arithmetic: unsigned STAGES-bit, no saturation. On wrap all FS bits fall, STG_STB=0 and WRAP=1.
- Reset asserted mid-operation clears immediately, including any in-flight edge in the synchroniser. After reset release, a low FS01_n already present is counted once (prev=1 initial).

Test Plan:
- Reset and idle: SIM_RST low then high, FS01_n=1 for 20 cycles -> FS=0, FS_n=all-ones, STG_STB=0, WRAP=0 throughout.
- Basic count (STAGES=4, SYNC_STAGES=2): 5 FS01_n low pulses of 3 cycles each, spaced 10 cycles apart.
  - FS steps 1,2,3,4,5.
  - STG_STB pulses are 0001, 0010, 0001, 0100, 0001.
  - Each update lands 2 edges after the first low sample.
- Wrap (STAGES=4): 16 pulses -> after the 15th FS=1111; after the 16th FS=0000, WRAP=1 and STG_STB=0000 for one cycle.
- Long low: FS01_n held low 50 cycles -> count increments exactly once.
- HOLD/SCLR:
  - 3 pulses with HOLD=1 -> FS unchanged.
  - SCLR asserted in the same cycle adv is active, with FS=0101 -> FS=0000, no strobe.
  - SCLR and HOLD both high -> clear wins.
- Async reset mid-flight: reset asserted one cycle after FS01_n falls with FS=0011 -> FS=0 immediately. After release with FS01_n=1 -> no advance.
